// File: rtl/fifo_ctrl.sv
// 16x9 FIFO controller driving an external storage array.
// Pointers and occupancy are registered; flags decode from the registered count.
// Read data is captured from the array on an accepted pop and presented one cycle later.
module fifo_ctrl #(
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [8:0] data_in,
  input  logic       pop,
  output logic [8:0] data_out,
  output logic       valid_out,
  output logic       full,
  output logic       empty,
  output logic       almost_full,
  output logic       almost_empty,
  output logic [4:0] count,
  output logic       overflow,
  output logic       underflow,
  output logic [3:0] mem_waddr,
  output logic [8:0] mem_wdata,
  output logic       mem_we,
  output logic [3:0] mem_raddr,
  output logic       mem_re,
  input  logic [8:0] mem_rdata
);

  localparam logic [4:0] DEPTH = 5'd16;
  localparam logic [4:0] AF_L  = 5'(AF_LEVEL);
  localparam logic [4:0] AE_L  = 5'(AE_LEVEL);

  logic [3:0] wr_ptr_q, rd_ptr_q;
  logic [4:0] count_q, count_d;
  logic [8:0] data_out_q;
  logic       valid_out_q, overflow_q, underflow_q;
  logic       push_ok, pop_ok;

  // Accept decisions; held off while reset is asserted so the array is never touched.
  // A push into a full FIFO is allowed when a pop frees a slot in the same cycle.
  always_comb begin
    pop_ok  = pop && !rst && (count_q != '0);
    push_ok = push && !rst && ((count_q != DEPTH) || pop_ok);
  end

  // Next occupancy: simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy, read-data and status-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 4'd1;
      if (pop_ok) begin
        rd_ptr_q   <= rd_ptr_q + 4'd1;
        data_out_q <= mem_rdata;
      end
      count_q     <= count_d;
      valid_out_q <= pop_ok;
      overflow_q  <= push && !push_ok;
      underflow_q <= pop && !pop_ok;
    end
  end

  // Array ports and flag decode.
  always_comb begin
    mem_we       = push_ok;
    mem_waddr    = wr_ptr_q;
    mem_wdata    = data_in;
    mem_re       = pop_ok;
    mem_raddr    = rd_ptr_q;
    data_out     = data_out_q;
    valid_out    = valid_out_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
    count        = count_q;
    full         = (count_q == DEPTH);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AF_L);
    almost_empty = (count_q <= AE_L);
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl: directed vectors, expected read words queued at pop issue
// and matched by an independent monitor against data_out/valid_out.
module tb_fifo_ctrl;

  logic       clk, rst, push, pop;
  logic [8:0] data_in, data_out, mem_wdata, mem_rdata;
  logic       valid_out, full, empty, almost_full, almost_empty;
  logic       overflow, underflow, mem_we, mem_re;
  logic [4:0] count;
  logic [3:0] mem_waddr, mem_raddr;

  fifo_ctrl #(.AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_raddr(mem_raddr), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  // Storage array model: synchronous write, combinational read.
  logic [8:0] mem [16];
  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem_re ? mem[mem_raddr] : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [8:0]  data;
    int unsigned cyc;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle: check combinational array strobes, queue expected read word, clock.
  task automatic step(input logic p, input logic [8:0] d, input logic r,
                      input logic exp_we, input logic exp_re, input logic [8:0] exp_d);
    push = p; data_in = d; pop = r;
    #1;
    chk("mem_we", mem_we, exp_we);
    chk("mem_re", mem_re, exp_re);
    if (exp_re) exp_q.push_back('{data: exp_d, cyc: cyc + 1});
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; data_in = '0;
  endtask

  // Monitor: each valid_out must match the oldest expected word, on the expected cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rd_unexpected: got valid data %h expected no output (cyc %0d)", data_out, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.data !== data_out || e.cyc != cyc) begin
            n_err++;
            $display("FAIL rd_data: got %h at cyc %0d expected %h at cyc %0d", data_out, cyc, e.data, e.cyc);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        n_chk++;
        n_err++;
        e = exp_q.pop_front();
        $display("FAIL rd_missing: got valid_out=%b expected data %h at cyc %0d", valid_out, e.data, e.cyc);
      end
    end
  end

  initial begin
    rst = 1'b1; push = 1'b1; pop = 1'b1; data_in = 9'h1FF;
    #3;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    push = 1'b0; pop = 1'b0; data_in = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill to full, watching threshold flags.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 9'h100 + 9'(i), 1'b0, 1'b1, 1'b0, '0);
      chk("fill_count", count, i + 1);
      chk("fill_afull", almost_full, (i + 1) >= 14);
      chk("fill_aempty", almost_empty, (i + 1) <= 2);
      chk("fill_full", full, (i + 1) == 16);
    end
    step(1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0, '0);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 16);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    chk("ovf_clear", overflow, 0);

    // Drain in order.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b1, 9'h100 + 9'(i));
      chk("drain_count", count, 15 - i);
    end
    chk("drain_empty", empty, 1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    chk("udf_pulse", underflow, 1);
    chk("udf_valid", valid_out, 0);
    chk("udf_empty", empty, 1);

    // Fill 10 / drain 10 three times across pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 9'h020 + 9'(r * 10 + i), 1'b0, 1'b1, 1'b0, '0);
      chk("wrap_count", count, 10);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1, 9'h020 + 9'(r * 10 + i));
      chk("wrap_empty", count, 0);
    end

    // Simultaneous push and pop while full.
    for (int i = 0; i < 16; i++) step(1'b1, 9'h0C0 + 9'(i), 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 9'h1AA, 1'b1, 1'b1, 1'b1, 9'h0C0);
    chk("fullpp_count", count, 16);
    chk("fullpp_full", full, 1);
    chk("fullpp_ovf", overflow, 0);
    for (int i = 1; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1, 9'h0C0 + 9'(i));
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, 9'h1AA);
    chk("fullpp_empty", empty, 1);

    // Simultaneous push and pop while empty.
    step(1'b1, 9'h055, 1'b1, 1'b1, 1'b0, '0);
    chk("emptypp_udf", underflow, 1);
    chk("emptypp_count", count, 1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, 9'h055);
    chk("emptypp_after", count, 0);

    // Asynchronous reset between edges with 7 words held.
    for (int i = 0; i < 8; i++) step(1'b1, 9'h1E0 + 9'(i), 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, 9'h1E0);
    chk("pre_rst_count", count, 7);
    chk("pre_rst_valid", valid_out, 1);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_valid", valid_out, 0);
    chk("arst_dout", data_out, 0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    chk("post_rst_udf", underflow, 1);
    chk("post_rst_count", count, 0);
    step(1'b1, 9'h0AB, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, 9'h0AB);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
